// File: rtl/cdb_arbiter_if.sv
// Bundle of the requester-side handshake and CDB broadcast signals for cdb_arbiter.
// slave = the arbiter; master = the requesters and the ROB/RS side that drive and observe it.
`ifndef Reg_Lock_Width
`define Reg_Lock_Width 5
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Addr_Width
`define Addr_Width 32
`endif

interface cdb_arbiter_if #(
  parameter int N       = 3,
  parameter int ENTRY_W = `Reg_Lock_Width,
  parameter int DATA_W  = `Data_Width,
  parameter int ADDR_W  = `Addr_Width
);
  logic                 flush;
  logic [N-1:0]         req_valid;
  logic [N*ENTRY_W-1:0] req_entry;
  logic [N*DATA_W-1:0]  req_value;
  logic [N*ADDR_W-1:0]  req_addr;
  logic [N-1:0]         req_ready;
  logic [ENTRY_W-1:0]   cdb_entry;
  logic [DATA_W-1:0]    cdb_value;
  logic [ADDR_W-1:0]    cdb_addr;
  logic                 cdb_is_branch;
  logic [2:0]           grant_id;

  modport slave (
    input  flush, req_valid, req_entry, req_value, req_addr,
    output req_ready, cdb_entry, cdb_value, cdb_addr, cdb_is_branch, grant_id
  );

  modport master (
    output flush, req_valid, req_entry, req_value, req_addr,
    input  req_ready, cdb_entry, cdb_value, cdb_addr, cdb_is_branch, grant_id
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one requester wins per cycle, its payload is broadcast next cycle.
// Define CDB_BRANCH_PRIO_EN to restrict the search to branch requesters whenever any of them is valid.
`ifndef Reg_Lock_Width
`define Reg_Lock_Width 5
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Addr_Width
`define Addr_Width 32
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock 5'd31
`endif

module cdb_arbiter #(
  parameter int                   N           = 3,
  parameter int                   ENTRY_W     = `Reg_Lock_Width,
  parameter int                   DATA_W      = `Data_Width,
  parameter int                   ADDR_W      = `Addr_Width,
  parameter logic [ENTRY_W-1:0]   NO_LOCK     = `Reg_No_Lock,
  parameter logic [N-1:0]         BRANCH_MASK = 3'b100
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [N-1:0]       eligible;
  logic [N-1:0]       upper;
  logic [N-1:0]       pool;
  logic [N-1:0]       grant_vec;
  logic [2:0]         win_idx;
  logic               found;
  logic               handshake;
  logic [ENTRY_W-1:0] win_entry;
  logic [DATA_W-1:0]  win_value;
  logic [ADDR_W-1:0]  win_addr;
  logic               win_branch;

  always_comb begin
    // NOTE: every variable of a combinational block gets a default first, so no path infers a latch.
    eligible = bus.req_valid;
`ifdef CDB_BRANCH_PRIO_EN
    if (|(bus.req_valid & BRANCH_MASK)) eligible = bus.req_valid & BRANCH_MASK;
`endif
  end

  // Candidates at or above rr_ptr take precedence; otherwise wrap to the lowest index.
  always_comb begin
    upper     = '0;
    grant_vec = '0;
    win_idx   = '0;
    next_ptr  = rr_ptr;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      upper[i] = eligible[i] && (PTR_W'(i) >= rr_ptr);
    end
    pool = (|upper) ? upper : eligible;
    for (int i = 0; i < N; i++) begin
      if (pool[i] && !found) begin
        found        = 1'b1;
        grant_vec[i] = 1'b1;
        win_idx      = 3'(i);
        next_ptr     = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign bus.req_ready = (rst || bus.flush) ? '0 : grant_vec;
  assign handshake     = |(bus.req_ready & bus.req_valid);

  always_comb begin
    win_entry  = '0;
    win_value  = '0;
    win_addr   = '0;
    win_branch = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_vec[i]) begin
        win_entry  = bus.req_entry[i*ENTRY_W +: ENTRY_W];
        win_value  = bus.req_value[i*DATA_W +: DATA_W];
        win_addr   = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_branch = BRANCH_MASK[i];
      end
    end
  end

  // A tag of NO_LOCK from a requester passes through unchanged and simply reads as idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      rr_ptr            <= '0;
      bus.cdb_entry     <= NO_LOCK;
      bus.cdb_value     <= '0;
      bus.cdb_addr      <= '0;
      bus.cdb_is_branch <= 1'b0;
      bus.grant_id      <= '0;
    end else if (handshake) begin
      rr_ptr            <= next_ptr;
      bus.cdb_entry     <= win_entry;
      bus.cdb_value     <= win_value;
      bus.cdb_addr      <= win_addr;
      bus.cdb_is_branch <= win_branch;
      bus.grant_id      <= win_idx;
    end else begin
      bus.cdb_entry     <= NO_LOCK;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then random traffic
// compared against a visit-order reference model of the round-robin rule.
module tb_cdb_arbiter;
  localparam int                 N       = 3;
  localparam int                 ENTRY_W = 5;
  localparam int                 DATA_W  = 32;
  localparam int                 ADDR_W  = 32;
  localparam logic [ENTRY_W-1:0] NO_LOCK = 5'd31;
  localparam logic [N-1:0]       BMASK   = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N(N), .ENTRY_W(ENTRY_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cdb_arbiter #(
    .N(N), .ENTRY_W(ENTRY_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .NO_LOCK(NO_LOCK), .BRANCH_MASK(BMASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: pointer and the broadcast expected on the bus in the current cycle.
  int                 ptr;
  int                 last_grant;
  logic [ENTRY_W-1:0] exp_entry;
  logic [DATA_W-1:0]  exp_value;
  logic [ADDR_W-1:0]  exp_addr;
  logic               exp_branch;
  logic [2:0]         exp_gid;

  logic [ENTRY_W-1:0] ent [N];
  logic [DATA_W-1:0]  val [N];
  logic [ADDR_W-1:0]  adr [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk requesters in order starting at p; the first eligible one wins.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    int           order [$];
    logic [N-1:0] cand;
    cand = v;
`ifdef CDB_BRANCH_PRIO_EN
    if ((v & BMASK) != '0) cand = v & BMASK;
`endif
    for (int k = 0; k < N; k++) order.push_back((p + k) % N);
    foreach (order[j]) if (cand[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic step(input string tag, input logic [N-1:0] v, input logic fl);
    int w;
    bus.req_valid = v;
    bus.flush     = fl;
    for (int i = 0; i < N; i++) begin
      bus.req_entry[i*ENTRY_W +: ENTRY_W] = ent[i];
      bus.req_value[i*DATA_W +: DATA_W]   = val[i];
      bus.req_addr[i*ADDR_W +: ADDR_W]    = adr[i];
    end
    w = fl ? -1 : model_pick(v, ptr);
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus.req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
    check({tag, "_entry"}, 64'(bus.cdb_entry), 64'(exp_entry));
    if (exp_entry != NO_LOCK) begin
      check({tag, "_value"},  64'(bus.cdb_value),     64'(exp_value));
      check({tag, "_addr"},   64'(bus.cdb_addr),      64'(exp_addr));
      check({tag, "_branch"}, 64'(bus.cdb_is_branch), 64'(exp_branch));
      check({tag, "_gid"},    64'(bus.grant_id),      64'(exp_gid));
    end
    if (w >= 0) begin
      exp_entry  = ent[w];
      exp_value  = val[w];
      exp_addr   = adr[w];
      exp_branch = BMASK[w];
      exp_gid    = 3'(w);
      ptr        = (w + 1) % N;
    end else begin
      exp_entry = NO_LOCK;
    end
    last_grant = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.flush     = 1'b1;
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  64'(bus.req_ready),     64'd0);
    check("rst_entry",  64'(bus.cdb_entry),     64'(NO_LOCK));
    check("rst_value",  64'(bus.cdb_value),     64'd0);
    check("rst_addr",   64'(bus.cdb_addr),      64'd0);
    check("rst_branch", 64'(bus.cdb_is_branch), 64'd0);
    check("rst_gid",    64'(bus.grant_id),      64'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    ptr           = 0;
    exp_entry     = NO_LOCK;
  endtask

  logic [N-1:0] pend;

  initial begin
    for (int i = 0; i < N; i++) begin
      ent[i] = NO_LOCK;
      val[i] = '0;
      adr[i] = '0;
    end
    exp_value = '0; exp_addr = '0; exp_branch = 1'b0; exp_gid = '0;
    last_grant = -1;

    // Reset, then idle bus for five cycles.
    do_reset();
    for (int c = 0; c < 5; c++) step("idle", 3'b000, 1'b0);

    // All three valid with tags 1/2/3: rotating grants, broadcast one cycle later.
    ent[0] = 5'd1; ent[1] = 5'd2; ent[2] = 5'd3;
    val[0] = 32'h11; val[1] = 32'h22; val[2] = 32'h33;
    for (int c = 0; c < 6; c++) step("rr", 3'b111, 1'b0);
    step("rr_tail", 3'b000, 1'b0);

    // Lone requester 0 granted back-to-back.
    ent[0] = 5'd5; val[0] = 32'hDEADBEEF; adr[0] = 32'h0000_1000;
    for (int c = 0; c < 3; c++) step("solo", 3'b001, 1'b0);
    step("solo_tail", 3'b000, 1'b0);

    // Branch requester: outcome in value[1:0], is_branch set on the bus.
    ent[2] = 5'd9; val[2] = 32'h2; adr[2] = '0;
    step("br", 3'b100, 1'b0);
    step("br_tail", 3'b000, 1'b0);

    // Flush while 011 valid: registered broadcast completes, no grant, pointer held.
    ent[0] = 5'd4; ent[1] = 5'd6; val[0] = 32'hA0; val[1] = 32'hB1;
    step("fl_pre", 3'b011, 1'b0);
    step("fl", 3'b011, 1'b1);
    step("fl_post", 3'b011, 1'b0);
    step("fl_tail", 3'b000, 1'b0);

    // A request tagged NO_LOCK is granted but reads as idle.
    ent[1] = NO_LOCK;
    step("nolock", 3'b010, 1'b0);
    step("nolock_tail", 3'b000, 1'b0);

`ifdef CDB_BRANCH_PRIO_EN
    do_reset();
    ent[0] = 5'd1; ent[1] = 5'd2; ent[2] = 5'd3;
    step("prio_br", 3'b111, 1'b0);
    step("prio_0", 3'b011, 1'b0);
    step("prio_1", 3'b011, 1'b0);
    step("prio_tail", 3'b000, 1'b0);
`endif

    // Random traffic: requesters hold valid and payload until the model says they were granted.
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          ent[i]  = ENTRY_W'($urandom);
          val[i]  = $urandom;
          adr[i]  = ($urandom_range(0, 1) == 1) ? $urandom : '0;
        end
      end
      step("rnd", pend, ($urandom_range(0, 15) == 0));
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end
    step("rnd_tail", 3'b000, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
